scan_decoder: RTL and testbench

- Parametrised, registered successor to the team's 3-to-8 enabled decoder: an SEL_W-to-2^SEL_W one-hot decoder with enable.
- Two modes:
  - direct: decodes a loaded select code.
  - scan: auto-steps through every output with a programmable dwell time.
- Drives one-hot strobes such as LED/digit scanning and channel selects in board-level designs.
- All outputs are registered.

---
 rtl/scan_decoder_pkg.sv | 26 ++
 rtl/onehot_dec.sv | 20 ++
 rtl/scan_decoder.sv | 83 ++++++++
 tb/tb_scan_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared state encoding, mode constants and next-state helper.
`default_nettype none

package scan_decoder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DIRECT = 2'd1;
  localparam state_t SCAN   = 2'd2;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic state_t next_state(input logic en, input logic mode);
    if (!en)
      return IDLE;
    else if (mode == MODE_SCAN)
      return SCAN;
    else
      return DIRECT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_dec.sv
// onehot_dec: combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
`default_nettype none

module onehot_dec #(
  parameter int SEL_W = 3,
  localparam int OUTS = 1 << SEL_W
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUTS-1:0]  out
);

  always_comb begin
    out      = '0;
    out[sel] = en;
  end

endmodule

`default_nettype wire

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with direct (loaded) and
// auto-scan (programmable dwell) modes.
`default_nettype none

module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DIV_W = 8,
  localparam int OUTS = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [SEL_W-1:0] sel,
  input  logic [DIV_W-1:0] div,
  output logic [OUTS-1:0]  d,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_cur;
  logic [DIV_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             wrap_nxt;
  logic [OUTS-1:0]  d_nxt;

  // Dwell always restarts from zero on entry into scan, whatever cnt holds.
  assign cnt_cur = (state == SCAN) ? cnt : '0;

  always_comb begin
    state_nxt = next_state(en, mode);
    cnt_nxt   = '0;
    idx_nxt   = idx;
    wrap_nxt  = 1'b0;
    case (state_nxt)
      SCAN: begin
        if (load) begin
          idx_nxt = sel;
        end else if (cnt_cur >= div) begin
          idx_nxt  = idx + SEL_W'(1);
          wrap_nxt = (idx == {SEL_W{1'b1}});
        end else begin
          cnt_nxt = cnt_cur + DIV_W'(1);
        end
      end
      default: begin
        if (load)
          idx_nxt = sel;
      end
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .en  (en),
    .sel (idx_nxt),
    .out (d_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
      d     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      wrap  <= wrap_nxt;
      d     <= d_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed + random stimulus against a behavioural model.
`default_nettype none

module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, mode, load;
  logic [2:0] sel;
  logic [7:0] div;
  logic [7:0] d;
  logic [2:0] idx;
  logic       wrap;

  logic        sw_en = 1'b1, sw_mode = 1'b1, sw_load = 1'b0;
  logic [7:0]  sw_div = 8'd2;
  logic [1:0]  sel2 = 2'd0, idx2;
  logic [3:0]  sel4 = 4'd0, idx4;
  logic [3:0]  d2;
  logic [15:0] d4;
  logic        wrap2, wrap4;

  scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .sel(sel), .div(div), .d(d), .idx(idx), .wrap(wrap)
  );

  scan_decoder #(.SEL_W(2), .DIV_W(8)) u_sw2 (
    .clk(clk), .rst_n(rst_n), .en(sw_en), .mode(sw_mode), .load(sw_load),
    .sel(sel2), .div(sw_div), .d(d2), .idx(idx2), .wrap(wrap2)
  );

  scan_decoder #(.SEL_W(4), .DIV_W(8)) u_sw4 (
    .clk(clk), .rst_n(rst_n), .en(sw_en), .mode(sw_mode), .load(sw_load),
    .sel(sel4), .div(sw_div), .d(d4), .idx(idx4), .wrap(wrap4)
  );

  int errors = 0;
  int checks = 0;

  // Model: position in the 8-entry ring and cycles already spent there.
  int         m_idx;
  int         m_hold;
  logic [7:0] m_d;
  logic       m_wrap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_hold = 0; m_d = 8'h00; m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    m_wrap = 1'b0;
    if (load)
      m_idx = int'(sel);
    if (!en || !mode || load) begin
      m_hold = 0;
    end else if (m_hold >= int'(div)) begin
      m_wrap = (m_idx == 7);
      m_idx  = (m_idx + 1) % 8;
      m_hold = 0;
    end else begin
      m_hold = m_hold + 1;
    end
    m_d = en ? (8'h01 << m_idx) : 8'h00;
  endtask

  task automatic cyc(input logic e, input logic m, input logic l,
                     input int s, input int dv, input string tag);
    @(negedge clk);
    en = e; mode = m; load = l; sel = s[2:0]; div = dv[7:0];
    @(posedge clk);
    #1;
    model_edge();
    check({tag, ".d"}, 32'(d), 32'(m_d));
    check({tag, ".idx"}, 32'(idx), 32'(m_idx));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    logic [7:0] exp_d [8];
    logic       exp_w [8];
    int         nwrap;
    int         n;
    logic       seen;

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel = 3'd0; div = 8'd0;
    model_reset();
    #1;
    check("reset.d", 32'(d), 32'h0);
    check("reset.idx", 32'(idx), 32'h0);
    check("reset.wrap", 32'(wrap), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Preload while disabled, then enable.
    cyc(1'b0, 1'b0, 1'b1, 5, 0, "idle_load");
    check("idle_load.idx5", 32'(idx), 32'd5);
    check("idle_load.d0", 32'(d), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, "en_on");
    check("en_on.d20", 32'(d), 32'h20);

    // Direct decode of every code, then hold without load.
    for (int s = 0; s < 8; s++) begin
      cyc(1'b1, 1'b0, 1'b1, s, 0, "direct");
      check("direct.onehot", 32'(d), 32'h1 << s);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 2, 0, "direct_hold");
      check("direct_hold.d80", 32'(d), 32'h80);
    end

    // Scan div=2 from idx 6: two entry cycles at 6, three at 7, then wrap to 0.
    cyc(1'b1, 1'b0, 1'b1, 6, 2, "scan_prep");
    exp_d = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 0, 2, "scan_div2");
      check("scan_div2.seq_d", 32'(d), 32'(exp_d[k]));
      check("scan_div2.seq_wrap", 32'(wrap), 32'(exp_w[k]));
    end

    // div=0 advances every cycle: 16 cycles give two wraps.
    nwrap = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 0, 0, "scan_div0");
      nwrap += int'(wrap);
    end
    check("scan_div0.wraps", 32'(nwrap), 32'd2);

    // Live div reduction at cnt=5 steps on that very cycle.
    cyc(1'b1, 1'b1, 1'b1, 0, 9, "div9_load");
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b0, 0, 9, "div9_dwell");
    cyc(1'b1, 1'b1, 1'b0, 0, 1, "div_drop");
    check("div_drop.idx1", 32'(idx), 32'd1);

    // Load colliding with a step wins and restarts a full dwell.
    cyc(1'b1, 1'b1, 1'b1, 0, 2, "coll_load0");
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "coll_dw1");
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "coll_dw2");
    cyc(1'b1, 1'b1, 1'b1, 3, 2, "coll_step");
    check("coll_step.d08", 32'(d), 32'h08);
    check("coll_step.nowrap", 32'(wrap), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "coll_after1");
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "coll_after2");
    check("coll_after2.idx3", 32'(idx), 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "coll_after3");
    check("coll_after3.idx4", 32'(idx), 32'd4);

    // Scan -> direct freezes idx.
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "freeze_pre");
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 0, 2, "freeze");
      check("freeze.idx4", 32'(idx), 32'd4);
    end

    // Disable mid-dwell, re-enable resumes at idx with a full dwell.
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "dis_pre");
    cyc(1'b0, 1'b1, 1'b0, 0, 2, "dis");
    check("dis.d0", 32'(d), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 0, 2, "dis2");
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "reen1");
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "reen2");
    check("reen2.idx4", 32'(idx), 32'd4);
    cyc(1'b1, 1'b1, 1'b0, 0, 2, "reen3");
    check("reen3.idx5", 32'(idx), 32'd5);

    // Randomised traffic.
    for (int k = 0; k < 300; k++) begin
      cyc(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
          int'($urandom % 8), int'($urandom % 4), "rand");
    end

    // Asynchronous reset mid-scan, away from any clock edge.
    cyc(1'b1, 1'b1, 1'b1, 6, 1, "pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.d", 32'(d), 32'h0);
    check("async_rst.idx", 32'(idx), 32'h0);
    check("async_rst.wrap", 32'(wrap), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0; load = 1'b0;

    // Parameter sweep: wrap period OUTS*(div+1) at SEL_W=2 and SEL_W=4.
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(posedge clk); #1; seen = wrap2; end
    check("sw2.first_wrap", 32'(seen), 32'h1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1; n++; seen = wrap2;
      check("sw2.onehot", 32'(d2), 32'h1 << idx2);
    end
    check("sw2.period", 32'(n), 32'd12);

    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin @(posedge clk); #1; seen = wrap4; end
    check("sw4.first_wrap", 32'(seen), 32'h1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1; n++; seen = wrap4;
      check("sw4.onehot", 32'(d4), 32'h1 << idx4);
    end
    check("sw4.period", 32'(n), 32'd48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
